// File: rtl/sram_1rwm_initiator.sv
// Front end for a single-port masked SRAM macro: forwards ready/valid requests to the port
// and returns read data in order through a fall-through response FIFO.
module sram_1rwm_initiator #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 288,
  parameter int MASK_W    = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_valid,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [MASK_W-1:0] sram_wmask,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic              r_pending;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_rdPtr;
  logic [PW-1:0]     r_wrPtr;
  logic [DATA_W-1:0] r_mem [RSP_DEPTH];

  logic              w_fire;
  logic              w_readFire;
  logic              w_fifoEmpty;
  logic              w_enq;
  logic              w_deq;
  logic [CW:0]       w_credits;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A read in flight counts as an occupied slot, so the FIFO can never overflow.
  assign w_fifoEmpty = (r_count == '0);
  assign w_credits   = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
  assign req_ready   = req_write | (w_credits < DEPTH_C);
  assign w_fire      = req_valid & req_ready;
  assign w_readFire  = w_fire & ~req_write;

  assign sram_valid  = w_fire;
  assign sram_write  = req_valid & req_write;
  assign sram_addr   = req_valid ? req_addr : '0;
  assign sram_wdata  = req_valid ? req_wdata : '0;
  assign sram_wmask  = (req_valid & req_write) ? req_wmask : '0;

  assign rsp_valid   = r_pending | ~w_fifoEmpty;
  assign busy        = r_pending | ~w_fifoEmpty;
  assign rsp_rdata   = w_fifoEmpty ? sram_rdata : r_mem[r_rdPtr];

  // Captured data bypasses an empty FIFO and is stored only if the client stalls.
  assign w_deq       = ~w_fifoEmpty & rsp_ready;
  assign w_enq       = r_pending & (~w_fifoEmpty | ~rsp_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_count   <= '0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
    end else begin
      r_pending <= w_readFire;
      if (w_enq) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_deq) r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_wrPtr] <= sram_rdata;
  end

endmodule
